// File: rtl/pts_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: FSM state encoding.
package pts_pkg;

    typedef enum logic {
        PTS_IDLE  = 1'b0,
        PTS_SHIFT = 1'b1
    } pts_state_t;

endpackage

// File: rtl/flex_pts_sr.sv
// Load/shift register for the transmitter; the output bit is taken straight from a flop.
module flex_pts_sr #(
    parameter int NUM_BITS   = 4,
    parameter bit SHIFT_MSB  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [NUM_BITS-1:0] load_data_i,
    output logic                bit_o
);

    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] sr_d;

    // Shifting toward the output end refills with the idle level, so an
    // emptied register already presents IDLE_LEVEL on the line.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_data_i;
        end else if (shift_i) begin
            if (SHIFT_MSB) begin
                sr_d = {sr_q[NUM_BITS-2:0], IDLE_LEVEL};
            end else begin
                sr_d = {IDLE_LEVEL, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {NUM_BITS{IDLE_LEVEL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial transmitter: valid/ready word intake, strobe-paced bit output,
// one-cycle frame_done pulse after the last bit.
module flex_pts_tx
    import pts_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter bit SHIFT_MSB  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                shift_enable,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    pts_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load;
    logic             shift;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            PTS_IDLE: begin
                if (tx_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = PTS_SHIFT;
                end
            end
            PTS_SHIFT: begin
                if (shift_enable) begin
                    shift = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = PTS_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = PTS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PTS_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB),
        .IDLE_LEVEL(IDLE_LEVEL)
    ) u_sr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .shift_i    (shift),
        .load_data_i(tx_data),
        .bit_o      (serial_out)
    );

    // All outputs come from flops; ready/busy are decodes of the state register.
    assign tx_ready   = (state_q == PTS_IDLE);
    assign busy       = (state_q == PTS_SHIFT);
    assign frame_done = done_q;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Bench for flex_pts_tx: MSB- and LSB-first instances share stimulus and are checked
// every cycle against a word/bit-index model, plus directed literal expectations.
module tb_flex_pts_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         shift_enable = 1'b0;

    logic rdy_m, so_m, busy_m, fd_m;
    logic rdy_l, so_l, busy_l, fd_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flex_pts_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_m),
        .shift_enable(shift_enable), .serial_out(so_m), .busy(busy_m), .frame_done(fd_m)
    );

    flex_pts_tx #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_l),
        .shift_enable(shift_enable), .serial_out(so_l), .busy(busy_l), .frame_done(fd_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the accepted word and how many bits have been strobed out.
    bit           m_active = 1'b0;
    bit           m_done   = 1'b0;
    logic [N-1:0] m_word   = '0;
    int           m_k      = 0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (!m_active) begin
            if (tx_valid) begin
                m_active <= 1'b1;
                m_word   <= tx_data;
                m_k      <= 0;
            end
        end else if (shift_enable) begin
            m_k <= m_k + 1;
            if (m_k == N - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    function automatic logic exp_bit(input bit msb_first);
        if (!m_active) return 1'b1;
        return msb_first ? m_word[N-1-m_k] : m_word[m_k];
    endfunction

    always @(negedge clk) begin
        check("m_serial", 32'(so_m), 32'(exp_bit(1'b1)));
        check("m_ready",  32'(rdy_m), 32'(!m_active));
        check("m_busy",   32'(busy_m), 32'(m_active));
        check("m_done",   32'(fd_m), 32'(m_done));
        check("l_serial", 32'(so_l), 32'(exp_bit(1'b0)));
        check("l_ready",  32'(rdy_l), 32'(!m_active));
        check("l_busy",   32'(busy_l), 32'(m_active));
        check("l_done",   32'(fd_l), 32'(m_done));
    end

    // Bench-side StP receivers sharing shift_enable with the transmitters.
    logic [N-1:0] rx_m = '1;
    logic [N-1:0] rx_l = '1;
    always @(posedge clk) begin
        if (shift_enable) begin
            rx_m <= {rx_m[N-2:0], so_m};
            rx_l <= {so_l, rx_l[N-1:1]};
        end
    end

    task automatic wait_done(input string name, input int max, output int cyc);
        cyc = 0;
        while (fd_m !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_seen"}, 32'(fd_m), 32'(1));
    endtask

    task automatic send_frame(input string name, input logic [N-1:0] word);
        int cyc;
        @(negedge clk);
        tx_data = word; tx_valid = 1'b1; shift_enable = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done(name, 10, cyc);
        check({name, "_latency"}, 32'(cyc), 32'(N));
        check({name, "_rx_msb"}, 32'(rx_m), 32'(word));
        check({name, "_rx_lsb"}, 32'(rx_l), 32'(word));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] seq_m;
        logic [N-1:0] seq_l;
        int           busy_cnt;
        int           done_at;
        int           cyc;

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        check("rst_serial", 32'(so_m), 32'(1));
        check("rst_ready",  32'(rdy_m), 32'(1));
        check("rst_busy",   32'(busy_m), 32'(0));
        check("rst_done",   32'(fd_m), 32'(0));
        rst = 1'b0;

        // 4'b1011, strobe held high: MSB-first 1,0,1,1 and LSB-first 1,1,0,1.
        seq_m = 4'b1011;
        seq_l = 4'b1101;
        @(negedge clk);
        tx_data = 4'b1011; tx_valid = 1'b1; shift_enable = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("t2_bit_msb", 32'(so_m), 32'(seq_m[N-1-i]));
            check("t2_bit_lsb", 32'(so_l), 32'(seq_l[N-1-i]));
            @(negedge clk);
        end
        check("t2_done",  32'(fd_m), 32'(1));
        check("t2_ready", 32'(rdy_m), 32'(1));
        check("t2_rx",    32'(rx_m), 32'(4'b1011));
        shift_enable = 1'b0;

        // 4'b0110 with a strobe every third cycle while another word waits on tx_data.
        @(negedge clk);
        tx_data = 4'b0110; tx_valid = 1'b1; shift_enable = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_m) busy_cnt++;
            if (fd_m) begin
                done_at = c;
                tx_valid = 1'b0;
                shift_enable = 1'b0;
                break;
            end
            tx_data = 4'b1001;
            shift_enable = (c % 3 == 2);
        end
        check("t4_busy_cycles", 32'(busy_cnt), 32'(12));
        check("t4_done_at",     32'(done_at), 32'(12));
        check("t4_rx_msb",      32'(rx_m), 32'(4'b0110));
        check("t4_rx_lsb",      32'(rx_l), 32'(4'b0110));
        @(negedge clk);
        check("t4_single_done", 32'(fd_m), 32'(0));
        check("t4_not_taken",   32'(busy_m), 32'(0));

        // 4'b1100 aborted by reset after two strobes, then 4'b0011.
        @(negedge clk);
        tx_data = 4'b1100; tx_valid = 1'b1; shift_enable = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_abort_serial", 32'(so_m), 32'(1));
        check("t5_abort_done",   32'(fd_m), 32'(0));
        check("t5_abort_busy",   32'(busy_m), 32'(0));
        send_frame("t5_after", 4'b0011);

        // Reset coinciding with the last strobe: no frame_done.
        @(negedge clk);
        tx_data = 4'b1010; tx_valid = 1'b1; shift_enable = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_last_done",   32'(fd_m), 32'(0));
        check("rst_last_serial", 32'(so_m), 32'(1));

        // Reset wins over a handshake in IDLE.
        shift_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1; tx_valid = 1'b1; tx_data = 4'b0000;
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        check("rst_vs_hs_busy",  32'(busy_m), 32'(0));
        check("rst_vs_hs_ready", 32'(rdy_m), 32'(1));

        // Loopback: 4'hA then 4'h5 with the strobe held high.
        send_frame("t6_a", 4'hA);
        send_frame("t6_5", 4'h5);
        shift_enable = 1'b0;
        wait_done("t6_idle", 0, cyc);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
